montgomery_seq: RTL and testbench

Parametrised Montgomery sequencer: one external Montgomery multiplier core is time-shared across domain conversion, multiplication and back-conversion instead of using four hard-wired stages. It replaces the fixed four-instance wrapper chain in the modular-multiplier top level. It adds three things the chain lacks: mode selection, operand capture, and an error path. It sits between the host request interface and any core exposing the enable_p / done_irq_p protocol.

---
 rtl/montgomery_seq_pkg.sv | 107 ++++++++++
 rtl/montgomery_seq.sv | 165 ++++++++++++++++
 tb/tb_montgomery_seq.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_seq_pkg.sv
// Shared types and per-mode op tables for the Montgomery sequencer.
package montgomery_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'd0,
        MODE_SQR  = 2'd1,
        MODE_RAW  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operand sources a core op can draw from.
    typedef enum logic [2:0] {
        SRC_A, SRC_B, SRC_R, SRC_T0, SRC_T1, SRC_T2, SRC_ONE
    } src_t;

    // Where a core result is written back.
    typedef enum logic [1:0] {
        TGT_T0, TGT_T1, TGT_T2, TGT_Y
    } tgt_t;

    localparam int unsigned OPS_MUL = 4;
    localparam int unsigned OPS_SQR = 3;
    localparam int unsigned OPS_RAW = 1;

    // Index of the final core op for a mode.
    function automatic logic [1:0] last_step(input mode_t md);
        logic [1:0] r;
        r = 2'd0;
        case (md)
            MODE_MUL: r = 2'(OPS_MUL - 1);
            MODE_SQR: r = 2'(OPS_SQR - 1);
            MODE_RAW: r = 2'(OPS_RAW - 1);
            default:  r = 2'd0;
        endcase
        return r;
    endfunction

    // First operand of core op 'step'.
    function automatic src_t step_src_a(input mode_t md, input logic [1:0] step);
        src_t r;
        r = SRC_A;
        case (md)
            MODE_MUL: case (step)
                2'd0:    r = SRC_A;
                2'd1:    r = SRC_B;
                2'd2:    r = SRC_T0;
                default: r = SRC_T2;
            endcase
            MODE_SQR: case (step)
                2'd0:    r = SRC_A;
                2'd1:    r = SRC_T0;
                default: r = SRC_T2;
            endcase
            default:  r = SRC_A;
        endcase
        return r;
    endfunction

    // Second operand of core op 'step'.
    function automatic src_t step_src_b(input mode_t md, input logic [1:0] step);
        src_t r;
        r = SRC_B;
        case (md)
            MODE_MUL: case (step)
                2'd0, 2'd1: r = SRC_R;
                2'd2:       r = SRC_T1;
                default:    r = SRC_ONE;
            endcase
            MODE_SQR: case (step)
                2'd0:    r = SRC_R;
                2'd1:    r = SRC_T0;
                default: r = SRC_ONE;
            endcase
            default:  r = SRC_B;
        endcase
        return r;
    endfunction

    // Destination of the result of core op 'step'.
    function automatic tgt_t step_target(input mode_t md, input logic [1:0] step);
        tgt_t r;
        r = TGT_Y;
        case (md)
            MODE_MUL: case (step)
                2'd0:    r = TGT_T0;
                2'd1:    r = TGT_T1;
                2'd2:    r = TGT_T2;
                default: r = TGT_Y;
            endcase
            MODE_SQR: case (step)
                2'd0:    r = TGT_T0;
                2'd1:    r = TGT_T2;
                default: r = TGT_Y;
            endcase
            default:  r = TGT_Y;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/montgomery_seq.sv
// Montgomery sequencer: time-shares one external Montgomery core across
// domain conversion, multiplication and back-conversion.
module montgomery_seq
    import montgomery_seq_pkg::*;
#(
    parameter int NBITS = 2048,
    parameter int MSW   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_p,
    input  logic [1:0]       mode,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [NBITS-1:0] r_red,
    input  logic [MSW-1:0]   m_size,
    output logic             busy,
    output logic [NBITS-1:0] y,
    output logic             err,
    output logic             done_irq_p,
    output logic             core_start_p,
    output logic [NBITS-1:0] core_a,
    output logic [NBITS-1:0] core_b,
    output logic [NBITS-1:0] core_m,
    output logic [MSW-1:0]   core_m_size,
    input  logic [NBITS-1:0] core_y,
    input  logic             core_done_p
);

    state_t           state, state_next;
    mode_t            mode_q;
    logic [1:0]       step_q, step_n;
    logic [NBITS-1:0] a_q, b_q, r_q;
    logic [NBITS-1:0] t0, t1, t2;
    logic [NBITS-1:0] t0_n, t1_n, t2_n;
    logic [NBITS-1:0] core_a_n, core_b_n;
    logic             accept, rsvd_req, op_done, last_op;

    function automatic logic [NBITS-1:0] pick(
        input src_t s,
        input logic [NBITS-1:0] va, vb, vr, v0, v1, v2
    );
        logic [NBITS-1:0] r;
        r = '0;
        case (s)
            SRC_A:   r = va;
            SRC_B:   r = vb;
            SRC_R:   r = vr;
            SRC_T0:  r = v0;
            SRC_T1:  r = v1;
            SRC_T2:  r = v2;
            SRC_ONE: r = NBITS'(1);
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept   = (state == IDLE) && start_p;
    assign rsvd_req = (mode_t'(mode) == MODE_RSVD);
    assign op_done  = (state == WAIT) && core_done_p;
    assign last_op  = (step_q == last_step(mode_q));
    assign step_n   = step_q + 2'd1;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its sources.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path leaves state_next unassigned and
        // no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start_p) state_next = rsvd_req ? DONE : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (core_done_p) state_next = last_op ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        busy         = (state != IDLE);
        core_start_p = (state == ISSUE);
        done_irq_p   = (state == DONE);
    end

    // Write-back values and operands for the next core launch; the just
    // returned core_y is forwarded so the next op can use it immediately.
    always_comb begin
        t0_n = t0;
        t1_n = t1;
        t2_n = t2;
        if (op_done) begin
            case (step_target(mode_q, step_q))
                TGT_T0:  t0_n = core_y;
                TGT_T1:  t1_n = core_y;
                TGT_T2:  t2_n = core_y;
                default: ;
            endcase
        end
        if (state == IDLE) begin
            core_a_n = pick(step_src_a(mode_t'(mode), 2'd0), a, b, r_red, t0, t1, t2);
            core_b_n = pick(step_src_b(mode_t'(mode), 2'd0), a, b, r_red, t0, t1, t2);
        end else begin
            core_a_n = pick(step_src_a(mode_q, step_n), a_q, b_q, r_q, t0_n, t1_n, t2_n);
            core_b_n = pick(step_src_b(mode_q, step_n), a_q, b_q, r_q, t0_n, t1_n, t2_n);
        end
    end

    // Datapath: operand capture, step sequencing, result write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every datapath register is reset, including the
            // intermediate slots, so no value from an aborted operation
            // is ever observable afterwards.
            mode_q      <= MODE_MUL;
            step_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            t0          <= '0;
            t1          <= '0;
            t2          <= '0;
            y           <= '0;
            err         <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            core_m      <= '0;
            core_m_size <= '0;
        end else if (accept) begin
            mode_q      <= mode_t'(mode);
            step_q      <= 2'd0;
            a_q         <= a;
            b_q         <= b;
            r_q         <= r_red;
            core_m      <= m;
            core_m_size <= m_size;
            err         <= rsvd_req;
            if (rsvd_req) begin
                y <= '0;
            end else begin
                core_a <= core_a_n;
                core_b <= core_b_n;
            end
        end else if (op_done) begin
            t0 <= t0_n;
            t1 <= t1_n;
            t2 <= t2_n;
            if (step_target(mode_q, step_q) == TGT_Y) y <= core_y;
            if (!last_op) begin
                step_q <= step_n;
                core_a <= core_a_n;
                core_b <= core_b_n;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_seq.sv
// Directed bench for montgomery_seq with NBITS=8, m=13, r_red=3 and a
// latency-3 core model computing x*z*3 mod 13.
module tb_montgomery_seq;

    localparam int NBITS = 8;
    localparam int MSW   = 4;
    localparam int L     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_p = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [NBITS-1:0] a = '0, b = '0, m = 8'd13, r_red = 8'd3;
    logic [MSW-1:0]   m_size = 4'd4;
    logic             busy, err, done_irq_p, core_start_p;
    logic [NBITS-1:0] y, core_a, core_b, core_m, core_y;
    logic [MSW-1:0]   core_m_size;
    logic             core_done_p;
    logic             model_done = 1'b0, stray_done = 1'b0;
    logic [NBITS-1:0] model_y = '0;

    assign core_done_p = model_done | stray_done;
    assign core_y      = model_y;

    montgomery_seq #(.NBITS(NBITS), .MSW(MSW)) dut (
        .clk(clk), .rst(rst), .start_p(start_p), .mode(mode),
        .a(a), .b(b), .m(m), .r_red(r_red), .m_size(m_size),
        .busy(busy), .y(y), .err(err), .done_irq_p(done_irq_p),
        .core_start_p(core_start_p), .core_a(core_a), .core_b(core_b),
        .core_m(core_m), .core_m_size(core_m_size),
        .core_y(core_y), .core_done_p(core_done_p)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-run observation record, filled by the monitor.
    int               t_start = 0;
    int               n_start, n_done, done_rel, done_abs, busy_first;
    int               start_rel[8];
    logic [NBITS-1:0] op_a[8], op_b[8];
    logic [NBITS-1:0] y_done;
    logic             err_done, busy_after;
    int               stable_err, mcap_err;

    // Core model state.
    logic             pend = 1'b0;
    int               sc = 0;
    logic [NBITS-1:0] ca = '0, cb = '0;

    // Expected tables for the current run.
    int               exp_start[4];
    logic [NBITS-1:0] exp_a[4], exp_b[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NBITS-1:0] mont(input logic [NBITS-1:0] x, input logic [NBITS-1:0] z);
        int p;
        p = (int'(x) * int'(z) * 3) % 13;
        return NBITS'(p);
    endfunction

    always @(posedge clk) cyc++;

    // Core model: done L cycles after the launch cycle, result from the
    // operands captured at launch.
    always begin
        @(posedge clk);
        #1;
        model_done = 1'b0;
        if (pend && cyc == sc + L) begin
            model_done = 1'b1;
            model_y    = mont(ca, cb);
            pend       = 1'b0;
        end
    end

    // Monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (busy && busy_first < 0) busy_first = cyc - t_start;
            if (core_start_p) begin
                if (n_start < 8) begin
                    start_rel[n_start] = cyc - t_start;
                    op_a[n_start]      = core_a;
                    op_b[n_start]      = core_b;
                end
                n_start++;
                if (core_m !== 8'd13 || core_m_size !== 4'd4) mcap_err++;
                pend = 1'b1;
                sc   = cyc;
                ca   = core_a;
                cb   = core_b;
            end else if (pend && (core_a !== ca || core_b !== cb)) begin
                stable_err++;
            end
            if (done_irq_p) begin
                if (n_done == 0) begin
                    done_rel = cyc - t_start;
                    done_abs = cyc;
                    y_done   = y;
                    err_done = err;
                end
                n_done++;
            end
            if (n_done > 0 && cyc == done_abs + 1) busy_after = busy;
        end
    end

    task automatic clear_record();
        n_start    = 0;
        n_done     = 0;
        done_rel   = -1;
        done_abs   = -100;
        busy_first = -1;
        busy_after = 1'bx;
        y_done     = 'x;
        err_done   = 1'bx;
        stable_err = 0;
        mcap_err   = 0;
    endtask

    // Returns at #1 into cycle t+1, t being the cycle start_p is high.
    task automatic start_op(input logic [1:0] md, input logic [NBITS-1:0] aa, input logic [NBITS-1:0] bb);
        @(posedge clk);
        #1;
        clear_record();
        t_start = cyc;
        mode    = md;
        a       = aa;
        b       = bb;
        start_p = 1'b1;
        @(posedge clk);
        #1;
        start_p = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && n_done == 0; i++) @(posedge clk);
        check({name, "_done_seen"}, 32'(n_done > 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string name, input int nops, input int exp_done,
                             input logic [NBITS-1:0] exp_y, input logic exp_err);
        wait_done(name);
        check({name, "_y"}, 32'(y_done), 32'(exp_y));
        check({name, "_err"}, 32'(err_done), 32'(exp_err));
        check({name, "_done_cycle"}, 32'(done_rel), 32'(exp_done));
        check({name, "_done_count"}, 32'(n_done), 1);
        check({name, "_core_starts"}, 32'(n_start), 32'(nops));
        check({name, "_busy_first"}, 32'(busy_first), 1);
        check({name, "_busy_after"}, 32'(busy_after), 0);
        check({name, "_stable"}, 32'(stable_err), 0);
        check({name, "_mcapture"}, 32'(mcap_err), 0);
        for (int i = 0; i < nops && i < n_start; i++) begin
            check($sformatf("%s_start%0d_cycle", name, i), 32'(start_rel[i]), 32'(exp_start[i]));
            check($sformatf("%s_op%0d_a", name, i), 32'(op_a[i]), 32'(exp_a[i]));
            check($sformatf("%s_op%0d_b", name, i), 32'(op_b[i]), 32'(exp_b[i]));
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_y"}, 32'(y), 0);
        check({name, "_err"}, 32'(err), 0);
        check({name, "_done_irq"}, 32'(done_irq_p), 0);
        check({name, "_core_start"}, 32'(core_start_p), 0);
        check({name, "_core_a"}, 32'(core_a), 0);
        check({name, "_core_b"}, 32'(core_b), 0);
        check({name, "_core_m"}, 32'(core_m), 0);
        check({name, "_core_m_size"}, 32'(core_m_size), 0);
    endtask

    initial begin
        clear_record();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // MUL 5*7: t0=6, t1=11, t2=3, y=9.
        exp_start = '{1, 5, 9, 13};
        exp_a     = '{8'd5, 8'd7, 8'd6, 8'd3};
        exp_b     = '{8'd3, 8'd3, 8'd11, 8'd1};
        start_op(2'd0, 8'd5, 8'd7);
        check_run("mul", 4, 17, 8'd9, 1'b0);

        // SQR 5: t0=6, t2=4, y=12; second op squares t0.
        exp_start = '{1, 5, 9, 0};
        exp_a     = '{8'd5, 8'd6, 8'd4, 8'd0};
        exp_b     = '{8'd3, 8'd6, 8'd1, 8'd0};
        start_op(2'd1, 8'd5, 8'd0);
        check_run("sqr", 3, 13, 8'd12, 1'b0);

        // RAW 5*7 = 105*... -> 5*7*3 mod 13 = 1.
        exp_start = '{1, 0, 0, 0};
        exp_a     = '{8'd5, 8'd0, 8'd0, 8'd0};
        exp_b     = '{8'd7, 8'd0, 8'd0, 8'd0};
        start_op(2'd2, 8'd5, 8'd7);
        check_run("raw", 1, 5, 8'd1, 1'b0);

        // Reserved mode: immediate error completion, y cleared.
        start_op(2'd3, 8'd5, 8'd7);
        check_run("rsvd", 0, 1, 8'd0, 1'b1);

        // MUL with start_p and new operands at cycles 2-3 and stray
        // core_done_p in the ISSUE cycles 1 and 5; none may disturb it.
        exp_start = '{1, 5, 9, 13};
        exp_a     = '{8'd5, 8'd7, 8'd6, 8'd3};
        exp_b     = '{8'd3, 8'd3, 8'd11, 8'd1};
        start_op(2'd0, 8'd5, 8'd7);
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        start_p = 1'b1; mode = 2'd2; a = 8'd1; b = 8'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_p = 1'b0;
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        check_run("stray", 4, 17, 8'd9, 1'b0);

        // Reset in cycle 6 of a MUL aborts with no completion.
        start_op(2'd0, 8'd5, 8'd7);
        while (cyc < t_start + 6) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("abort");
        repeat (25) @(posedge clk);
        #1;
        check("abort_no_done", 32'(n_done), 0);
        check("abort_core_starts", 32'(n_start), 2);

        // Fresh RAW after the abort.
        exp_start = '{1, 0, 0, 0};
        exp_a     = '{8'd5, 8'd0, 8'd0, 8'd0};
        exp_b     = '{8'd7, 8'd0, 8'd0, 8'd0};
        start_op(2'd2, 8'd5, 8'd7);
        check_run("raw_after_abort", 1, 5, 8'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
